alu_result_buffer: RTL and testbench

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/alu_result_buffer.sv | 98 +++++++++
 tb/tb_alu_result_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// Captures {carry, result} from an ALU a fixed number of cycles after Start.
// Entries go into a first-word-fall-through FIFO, with a sticky flag for dropped captures.
module alu_result_buffer #(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     Start,
  input  logic [3:0]               RegOut,
  input  logic                     Carryout,
  input  logic                     OutReady,
  input  logic                     ClearErr,
  output logic [4:0]               OutData,
  output logic                     OutValid,
  output logic                     Busy,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  state_t            state;
  logic [3:0]        settleCnt;
  logic [4:0]        mem [DEPTH];
  logic [PtrW-1:0]   rdPtr;
  logic [PtrW-1:0]   wrPtr;
  logic [CntW-1:0]   count;
  logic              pushTry;
  logic              pushEn;
  logic              popEn;
  logic              dropEn;

  assign Full     = (count == CntW'(DEPTH));
  assign Empty    = (count == '0);
  assign OutValid = !Empty;
  assign Count    = count;
  assign Busy     = (state != IDLE);
  assign OutData  = Empty ? 5'b0 : mem[rdPtr];

  // A full FIFO still takes the push when the head leaves on the same edge.
  assign pushTry = (state == CAPTURE);
  assign popEn   = OutValid && OutReady;
  assign pushEn  = pushTry && (!Full || popEn);
  assign dropEn  = pushTry && Full && !popEn;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      settleCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state     <= SETTLE;
            settleCnt <= 4'(SETTLE_CYCLES - 1);
          end
        end
        SETTLE: begin
          if (settleCnt == 4'd0) state <= CAPTURE;
          else                   settleCnt <= settleCnt - 4'd1;
        end
        CAPTURE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + PtrW'(1);
      if (popEn)  rdPtr <= rdPtr + PtrW'(1);
      case ({pushEn, popEn})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
      if (dropEn)        Overflow <= 1'b1;
      else if (ClearErr) Overflow <= 1'b0;
    end
  end

  // Storage needs no reset: OutData is masked whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (pushEn) mem[wrPtr] <= {Carryout, RegOut};
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer with a queue-based scoreboard.
// A negedge monitor checks every popped entry against the expected queue.
module tb_alu_result_buffer;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] RegOut = 4'h0;
  logic       Carryout = 1'b0;
  logic       OutReady = 1'b0;
  logic       ClearErr = 1'b0;
  logic [4:0] OutData;
  logic       OutValid;
  logic       Busy;
  logic       Full;
  logic       Empty;
  logic [2:0] Count;
  logic       Overflow;

  int         tests = 0;
  int         fails = 0;
  logic [4:0] expQ[$];
  logic [4:0] monExp;

  alu_result_buffer #(.DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clock(clock), .reset(reset), .Start(Start), .RegOut(RegOut),
    .Carryout(Carryout), .OutReady(OutReady), .ClearErr(ClearErr),
    .OutData(OutData), .OutValid(OutValid), .Busy(Busy), .Full(Full),
    .Empty(Empty), .Count(Count), .Overflow(Overflow)
  );

  always #5 clock = ~clock;

  // A pop happens at the next rising edge whenever valid and ready are both high here.
  always @(negedge clock) begin
    if (reset && OutValid && OutReady) begin
      tests++;
      if (expQ.size() == 0) begin
        fails++;
        $display("FAIL pop: unexpected entry %0h with empty scoreboard", OutData);
      end else begin
        monExp = expQ.pop_front();
        if (OutData !== monExp) begin
          fails++;
          $display("FAIL pop: got %0h expected %0h", OutData, monExp);
        end else begin
          $display("[TB] pop %0h ok", OutData);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] %s = %0h ok", name, act);
    end
  endtask

  // Entered #1 after an edge with the FSM idle; returns #1 after the push edge.
  task automatic capture(input logic [3:0] val, input logic c, input bit expPush,
                         input bit popOnPush, input bit clrOnPush);
    RegOut   = val;
    Carryout = c;
    Start    = 1'b1;
    if (expPush) expQ.push_back({c, val});
    @(posedge clock); #1;
    Start = 1'b0;
    repeat (SETTLE - 1) @(posedge clock);
    @(posedge clock); #1;
    if (popOnPush) OutReady = 1'b1;
    if (clrOnPush) ClearErr = 1'b1;
    @(posedge clock); #1;
    OutReady = 1'b0;
    ClearErr = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget   = 0;
    OutReady = 1'b1;
    while (!Empty && budget < 20) begin
      @(posedge clock); #1;
      budget++;
    end
    OutReady = 1'b0;
    check({name, " empty after drain"}, 32'(Empty), 32'd1);
    check({name, " scoreboard drained"}, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset Count", 32'(Count), 32'd0);
    check("reset Empty", 32'(Empty), 32'd1);
    check("reset Full", 32'(Full), 32'd0);
    check("reset OutValid", 32'(OutValid), 32'd0);
    check("reset OutData", 32'(OutData), 32'd0);
    check("reset Busy", 32'(Busy), 32'd0);
    check("reset Overflow", 32'(Overflow), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Single capture with exact latency
    RegOut   = 4'hA;
    Carryout = 1'b1;
    Start    = 1'b1;
    expQ.push_back(5'h1A);
    @(posedge clock); #1;
    Start = 1'b0;
    check("single Busy after start", 32'(Busy), 32'd1);
    repeat (3) @(posedge clock);
    #1;
    check("single Busy before push", 32'(Busy), 32'd1);
    check("single OutValid before push", 32'(OutValid), 32'd0);
    @(posedge clock); #1;
    check("single OutValid", 32'(OutValid), 32'd1);
    check("single OutData", 32'(OutData), 32'h1A);
    check("single Count", 32'(Count), 32'd1);
    check("single Busy done", 32'(Busy), 32'd0);
    drain("single");

    // Second Start during SETTLE is ignored
    RegOut   = 4'h7;
    Carryout = 1'b0;
    Start    = 1'b1;
    expQ.push_back(5'h07);
    @(posedge clock); #1;
    Start = 1'b0;
    @(posedge clock); #1;
    Start = 1'b1;
    @(posedge clock); #1;
    Start = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    check("settle-start Count", 32'(Count), 32'd1);
    check("settle-start Busy", 32'(Busy), 32'd0);
    drain("settle-start");

    // Fill, overflow, and ClearErr behaviour
    for (int i = 1; i <= 4; i++) capture(4'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    check("fill Full", 32'(Full), 32'd1);
    check("fill Count", 32'(Count), 32'd4);
    check("fill Overflow clear", 32'(Overflow), 32'd0);
    capture(4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("drop Overflow", 32'(Overflow), 32'd1);
    check("drop Count", 32'(Count), 32'd4);
    capture(4'h9, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clear on drop Overflow", 32'(Overflow), 32'd1);
    ClearErr = 1'b1;
    @(posedge clock); #1;
    ClearErr = 1'b0;
    check("clear Overflow", 32'(Overflow), 32'd0);
    drain("overflow");

    // Push and pop on the same edge while full
    for (int i = 1; i <= 4; i++) capture(4'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    capture(4'h6, 1'b0, 1'b1, 1'b1, 1'b0);
    check("push+pop Count", 32'(Count), 32'd4);
    check("push+pop Overflow", 32'(Overflow), 32'd0);
    check("push+pop Full", 32'(Full), 32'd1);
    drain("push+pop");

    // Asynchronous reset during SETTLE with two entries held
    capture(4'h1, 1'b0, 1'b1, 1'b0, 1'b0);
    capture(4'h2, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pre-reset Count", 32'(Count), 32'd2);
    RegOut = 4'hF;
    Start  = 1'b1;
    @(posedge clock); #1;
    Start = 1'b0;
    @(posedge clock); #1;
    check("pre-reset Busy", 32'(Busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid-reset Count", 32'(Count), 32'd0);
    check("mid-reset Empty", 32'(Empty), 32'd1);
    check("mid-reset Busy", 32'(Busy), 32'd0);
    check("mid-reset OutData", 32'(OutData), 32'd0);
    expQ.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    check("post-reset Count", 32'(Count), 32'd0);
    check("post-reset Busy", 32'(Busy), 32'd0);

    // Normal operation resumes after reset
    capture(4'hC, 1'b1, 1'b1, 1'b0, 1'b0);
    check("resume OutData", 32'(OutData), 32'h1C);
    drain("resume");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
